// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial converter with a one-word holding register for gapless streaming
//
// Ports:
//   CLK        in   rising-edge clock
//   Reset      in   synchronous active-high reset
//   data_in    in   WIDTH-bit parallel word
//   data_valid in   data_in holds a valid word
//   data_ready out  a word can be accepted this cycle (registered, = ~hold_full)
//   x_out      out  serial bit stream, IDLE_LEVEL when no bit is presented
//   bit_valid  out  x_out carries a data bit this cycle
//   word_done  out  x_out carries the last bit of a word this cycle
module bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             word_done
);
    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             x_q, x_d;
    logic             bv_q, bv_d;
    logic             wd_q, wd_d;
    logic             accept, last, load, cur;

    // Outputs are computed from next state so they line up with the bit the
    // shifter holds after the edge.
    always_comb begin
        accept      = data_valid & ~hold_full_q;
        last        = (state_q == SHIFT) && (cnt_q == LAST);
        load        = hold_full_q && ((state_q == IDLE) || last);
        state_d     = load ? SHIFT : (last ? IDLE : state_q);
        cnt_d       = (load || last) ? '0 : ((state_q == SHIFT) ? cnt_q + 1'b1 : cnt_q);
        shreg_d     = load ? hold_q
                    : (state_q == SHIFT) ? (MSB_FIRST ? shreg_q << 1 : shreg_q >> 1)
                    : shreg_q;
        hold_d      = accept ? data_in : hold_q;
        hold_full_d = accept | (hold_full_q & ~load);
        cur         = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        x_d         = (state_d == SHIFT) ? cur : IDLE_LEVEL;
        bv_d        = (state_d == SHIFT);
        wd_d        = (state_d == SHIFT) && (cnt_d == LAST);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            x_q         <= IDLE_LEVEL;
            bv_q        <= 1'b0;
            wd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            x_q         <= x_d;
            bv_q        <= bv_d;
            wd_q        <= wd_d;
        end
    end

    assign data_ready = ~hold_full_q;
    assign x_out      = x_q;
    assign bit_valid  = bv_q;
    assign word_done  = wd_q;
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench for two serializer configurations (MSB-first/idle 0, LSB-first/idle 1)
module tb_bit_serializer;
    logic       CLK = 1'b0;
    logic       rst;
    logic [7:0] din [2];
    logic [1:0] dv, rdy, xo, bv, wd;
    logic       mon_en = 1'b0;
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    int         acc_cyc = 0;
    logic [1:0] q0 [$];
    logic [1:0] q1 [$];
    int         wd_log [$];
    localparam logic [1:0] IDL = 2'b10;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
        .CLK(CLK), .Reset(rst), .data_in(din[0]), .data_valid(dv[0]), .data_ready(rdy[0]),
        .x_out(xo[0]), .bit_valid(bv[0]), .word_done(wd[0])
    );
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u1 (
        .CLK(CLK), .Reset(rst), .data_in(din[1]), .data_valid(dv[1]), .data_ready(rdy[1]),
        .x_out(xo[1]), .bit_valid(bv[1]), .word_done(wd[1])
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, a, e, cyc);
    endtask

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [1:0] qpop(int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic push_word(int d, logic [7:0] w);
        logic [1:0] e;
        for (int i = 0; i < 8; i++) begin
            e = {(d == 0) ? w[7-i] : w[i], i == 7};
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    // Monitor: every presented bit is matched against the scoreboard; idle cycles must show the idle level.
    always @(negedge CLK) begin
        logic [1:0] e;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (bv[d]) begin
                    if (qsize(d) == 0) begin
                        total++;
                        $display("FAIL extra_bit_u%0d: bit_valid=1 x_out=%b, expected no bit (cycle %0d)", d, xo[d], cyc);
                    end else begin
                        e = qpop(d);
                        check($sformatf("x_out_u%0d", d), 32'(xo[d]), 32'(e[1]));
                        check($sformatf("word_done_u%0d", d), 32'(wd[d]), 32'(e[0]));
                    end
                end else begin
                    check($sformatf("idle_x_out_u%0d", d), 32'(xo[d]), 32'(IDL[d]));
                    check($sformatf("idle_word_done_u%0d", d), 32'(wd[d]), 32'd0);
                end
            end
            if (bv[0] && wd[0]) wd_log.push_back(cyc);
        end
    end

    // Holds data_valid high until the word is taken; returns just after the accepting edge.
    task automatic send(int d, logic [7:0] w, output int waits);
        waits = 0;
        dv[d] = 1'b1;
        din[d] = w;
        while (!rdy[d] && waits < 50) begin
            @(posedge CLK); #2;
            waits++;
        end
        if (!rdy[d]) begin
            total++;
            $display("FAIL send_timeout_u%0d: data_ready stayed 0, expected 1 within 50 cycles", d);
        end else begin
            push_word(d, w);
            @(posedge CLK); #2;
            acc_cyc = cyc;
            check($sformatf("ready_after_accept_u%0d", d), 32'(rdy[d]), 32'd0);
        end
        dv[d] = 1'b0;
    endtask

    task automatic drain(int d);
        int n = 0;
        while ((qsize(d) != 0 || bv[d]) && n < 100) begin
            @(posedge CLK); #2;
            n++;
        end
        check($sformatf("drained_u%0d", d), 32'(qsize(d)), 32'd0);
        repeat (3) @(posedge CLK);
        #2;
    endtask

    task automatic check_reset_state(string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_ready_u%0d", tag, d), 32'(rdy[d]), 32'd1);
            check($sformatf("%s_bit_valid_u%0d", tag, d), 32'(bv[d]), 32'd0);
            check($sformatf("%s_word_done_u%0d", tag, d), 32'(wd[d]), 32'd0);
            check($sformatf("%s_x_out_u%0d", tag, d), 32'(xo[d]), 32'(IDL[d]));
        end
    endtask

    initial begin
        int w;
        int a;
        rst = 1'b1;
        dv = '0;
        din[0] = '0;
        din[1] = '0;
        repeat (2) @(posedge CLK);
        #2;
        check_reset_state("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Single word: eight bits, word_done eight cycles after acceptance.
        wd_log.delete();
        send(0, 8'b1011_0010, w);
        a = acc_cyc;
        check("single_wait", 32'(w), 32'd0);
        drain(0);
        check("single_done_count", 32'(wd_log.size()), 32'd1);
        check("single_latency", 32'((wd_log.size() > 0) ? wd_log[0] - a : -1), 32'd8);

        // Sustained stream of three words with data_valid continuously high.
        wd_log.delete();
        send(0, 8'hA5, w);
        a = acc_cyc;
        check("a5_wait", 32'(w), 32'd0);
        send(0, 8'h3C, w);
        check("3c_wait", 32'(w), 32'd1);
        send(0, 8'hC3, w);
        check("c3_stall", 32'(w), 32'd7);
        drain(0);
        check("stream_done_count", 32'(wd_log.size()), 32'd3);
        if (wd_log.size() == 3) begin
            check("stream_first_done", 32'(wd_log[0] - a), 32'd8);
            check("stream_gap_1", 32'(wd_log[1] - wd_log[0]), 32'd8);
            check("stream_gap_2", 32'(wd_log[2] - wd_log[1]), 32'd8);
        end

        // Reset during the 4th bit of F0 with 0F held.
        send(0, 8'hF0, w);
        send(0, 8'h0F, w);
        @(posedge CLK); #2;
        @(posedge CLK); #2;
        check("fourth_bit_valid", 32'(bv[0]), 32'd1);
        check("fourth_bit_hold_full", 32'(rdy[0]), 32'd0);
        rst = 1'b1;
        @(posedge CLK); #2;
        q0.delete();
        rst = 1'b0;
        check_reset_state("midword_reset");
        repeat (12) @(posedge CLK);
        #2;

        // A word offered only while Reset is high must be dropped.
        rst = 1'b1;
        dv[0] = 1'b1;
        din[0] = 8'h81;
        @(posedge CLK); #2;
        rst = 1'b0;
        dv[0] = 1'b0;
        check_reset_state("reset_drop");
        repeat (12) @(posedge CLK);
        #2;

        // LSB-first instance with idle level 1.
        send(1, 8'h01, w);
        drain(1);
        send(1, 8'hB2, w);
        send(1, 8'h6A, w);
        drain(1);

        check("final_q0_empty", 32'(q0.size()), 32'd0);
        check("final_q1_empty", 32'(q1.size()), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
